// File: rtl/page_table_walker.sv
// Two-level page-table walker. It services TLB misses by reading 32-bit PTEs from
// main memory and answers with a one-cycle refill strobe or a one-cycle page-fault strobe.
module page_table_walker #(
  parameter int VPN_WIDTH      = 20,
  parameter int PFN_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ptbr,
  input  logic                 tlb_miss,
  input  logic [VPN_WIDTH-1:0] miss_vpn,
  output logic                 refill_en,
  output logic [VPN_WIDTH-1:0] refill_vpn,
  output logic [PFN_WIDTH-1:0] refill_pfn,
  output logic [31:0]          mem_addr,
  output logic                 mem_read_req,
  input  logic [31:0]          mem_data_in,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 fault,
  output logic [VPN_WIDTH-1:0] fault_vpn,
  output logic [1:0]           fault_code
);

  typedef enum logic [2:0] {IDLE, L1_REQ, L2_REQ, REFILL, FAULT, HOLD} state_t;

  typedef struct packed {
    logic [19:0] ppn;
    logic        leaf;
    logic        valid;
  } pte_t;

  localparam int         CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] FC_INVALID    = 2'd0;
  localparam logic [1:0] FC_MISALIGNED = 2'd1;
  localparam logic [1:0] FC_NONLEAF    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT    = 2'd3;

  state_t               state_q, state_d;
  logic [VPN_WIDTH-1:0] vpn_q, vpn_d;
  pte_t                 pte_q, pte_d;
  logic                 pte_vld_q, pte_vld_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic                 dropped_q, dropped_d;

  logic [31:0]          addr_d;
  logic                 req_d, busy_d;
  logic                 refill_en_d, fault_d;
  logic [VPN_WIDTH-1:0] refill_vpn_d, fault_vpn_d;
  logic [PFN_WIDTH-1:0] refill_pfn_d, pfn;
  logic [1:0]           fault_code_d, code;
  logic                 do_refill, do_fault;

  // Offset bits of the table base and the ignored PTE attribute bits.
  logic unused_bits;
  assign unused_bits = ^{ptbr[11:0], mem_data_in[11:2]};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    vpn_d        = vpn_q;
    pte_d        = pte_q;
    pte_vld_d    = 1'b0;
    tmo_d        = tmo_q;
    dropped_d    = dropped_q | ~tlb_miss;
    addr_d       = mem_addr;
    req_d        = mem_read_req;
    refill_en_d  = 1'b0;
    refill_vpn_d = refill_vpn;
    refill_pfn_d = refill_pfn;
    fault_d      = 1'b0;
    fault_vpn_d  = fault_vpn;
    fault_code_d = fault_code;
    do_refill    = 1'b0;
    do_fault     = 1'b0;
    code         = FC_INVALID;
    pfn          = '0;

    unique case (state_q)
      IDLE: begin
        if (tlb_miss) begin
          vpn_d     = miss_vpn;
          addr_d    = {ptbr[31:12], miss_vpn[VPN_WIDTH-1 -: 10], 2'b00};
          req_d     = 1'b1;
          tmo_d     = '0;
          dropped_d = 1'b0;
          state_d   = L1_REQ;
        end
      end
      L1_REQ, L2_REQ: begin
        // A returned PTE is captured first and decoded on the following cycle.
        if (pte_vld_q) begin
          if (!pte_q.valid) begin
            do_fault = 1'b1;
            code     = FC_INVALID;
          end else if (state_q == L1_REQ) begin
            if (!pte_q.leaf) begin
              addr_d  = {pte_q.ppn, vpn_q[9:0], 2'b00};
              req_d   = 1'b1;
              tmo_d   = '0;
              state_d = L2_REQ;
            end else if (pte_q.ppn[9:0] != 10'd0) begin
              do_fault = 1'b1;
              code     = FC_MISALIGNED;
            end else begin
              do_refill = 1'b1;
              pfn       = PFN_WIDTH'({pte_q.ppn[19:10], vpn_q[9:0]});
            end
          end else if (!pte_q.leaf) begin
            do_fault = 1'b1;
            code     = FC_NONLEAF;
          end else begin
            do_refill = 1'b1;
            pfn       = PFN_WIDTH'(pte_q.ppn);
          end
        end else if (mem_ready) begin
          pte_d     = pte_t'({mem_data_in[31:12], mem_data_in[1:0]});
          pte_vld_d = 1'b1;
          req_d     = 1'b0;
        end else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d    = 1'b0;
          do_fault = 1'b1;
          code     = FC_TIMEOUT;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      REFILL, FAULT: state_d = HOLD;
      // Leave only once the MMU has let go of the miss that was just answered.
      HOLD: if (!tlb_miss || dropped_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_refill) begin
      refill_en_d  = 1'b1;
      refill_vpn_d = vpn_q;
      refill_pfn_d = pfn;
      state_d      = REFILL;
    end
    if (do_fault) begin
      fault_d      = 1'b1;
      fault_vpn_d  = vpn_q;
      fault_code_d = code;
      state_d      = FAULT;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      vpn_q        <= '0;
      pte_q        <= '0;
      pte_vld_q    <= 1'b0;
      tmo_q        <= '0;
      dropped_q    <= 1'b0;
      mem_addr     <= '0;
      mem_read_req <= 1'b0;
      busy         <= 1'b0;
      refill_en    <= 1'b0;
      refill_vpn   <= '0;
      refill_pfn   <= '0;
      fault        <= 1'b0;
      fault_vpn    <= '0;
      fault_code   <= '0;
    end else begin
      state_q      <= state_d;
      vpn_q        <= vpn_d;
      pte_q        <= pte_d;
      pte_vld_q    <= pte_vld_d;
      tmo_q        <= tmo_d;
      dropped_q    <= dropped_d;
      mem_addr     <= addr_d;
      mem_read_req <= req_d;
      busy         <= busy_d;
      refill_en    <= refill_en_d;
      refill_vpn   <= refill_vpn_d;
      refill_pfn   <= refill_pfn_d;
      fault        <= fault_d;
      fault_vpn    <= fault_vpn_d;
      fault_code   <= fault_code_d;
    end
  end

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: a sparse memory model answers PTE reads,
// and a walk model computes the expected refill/fault, addresses and latency.
module tb_page_table_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ptbr = '0;
  logic        tlb_miss = 1'b0;
  logic [19:0] miss_vpn = '0;
  logic        refill_en;
  logic [19:0] refill_vpn;
  logic [19:0] refill_pfn;
  logic [31:0] mem_addr;
  logic        mem_read_req;
  logic [31:0] mem_data_in = '0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        fault;
  logic [19:0] fault_vpn;
  logic [1:0]  fault_code;

  int tests_run = 0;
  int tests_failed = 0;

  page_table_walker #(.VPN_WIDTH(20), .PFN_WIDTH(20), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .ptbr(ptbr), .tlb_miss(tlb_miss), .miss_vpn(miss_vpn),
    .refill_en(refill_en), .refill_vpn(refill_vpn), .refill_pfn(refill_pfn),
    .mem_addr(mem_addr), .mem_read_req(mem_read_req), .mem_data_in(mem_data_in),
    .mem_ready(mem_ready), .busy(busy), .fault(fault), .fault_vpn(fault_vpn),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [31:0]];
  int          mem_lat = 4;
  bit          mem_mute = 1'b0;
  int          req_cnt = 0;
  int          inject_req = 0;
  int          inject_done = 0;
  logic [31:0] addr_log[$];
  int          burst_log[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (inject_req != inject_done) begin
      mem_ready   = 1'b1;
      mem_data_in = 32'h0002_0001;
      inject_done = inject_req;
    end else if (mem_read_req && !rst) begin
      if (req_cnt == 0) addr_log.push_back(mem_addr);
      req_cnt++;
      if (!mem_mute && req_cnt == mem_lat) begin
        mem_ready   = 1'b1;
        mem_data_in = mem_rd(mem_addr);
      end
    end else begin
      if (req_cnt > 0) burst_log.push_back(req_cnt);
      req_cnt = 0;
    end
  end

  int refill_cnt = 0;
  int fault_cnt = 0;
  bit both_seen = 1'b0;
  always @(negedge clk) begin
    if (refill_en) refill_cnt++;
    if (fault) fault_cnt++;
    if (refill_en && fault) both_seen = 1'b1;
  end

  // ---------------- reference model ----------------
  // kind: 1 refill, 2 fault. Latency counts cycles from the miss being sampled.
  function automatic void model_walk(input logic [31:0] base, input logic [19:0] vpn, input int m,
      output int kind, output logic [19:0] pfn, output logic [1:0] code, output int n_acc,
      output logic [31:0] a1, output logic [31:0] a2, output int lat);
    logic [31:0] p1, p2;
    kind = 2; pfn = '0; code = 2'd0; a2 = '0;
    a1 = {base[31:12], vpn[19:10], 2'b00};
    p1 = mem_rd(a1);
    n_acc = 1;
    if (!p1[0]) code = 2'd0;
    else if (p1[1]) begin
      if (p1[21:12] != 10'd0) code = 2'd1;
      else begin kind = 1; pfn = {p1[31:22], vpn[9:0]}; end
    end else begin
      n_acc = 2;
      a2 = {p1[31:12], vpn[9:0], 2'b00};
      p2 = mem_rd(a2);
      if (!p2[0]) code = 2'd0;
      else if (!p2[1]) code = 2'd2;
      else begin kind = 1; pfn = p2[31:12]; end
    end
    lat = (n_acc == 2) ? 2 * m + 3 : m + 2;
  endfunction

  // ---------------- walk driver ----------------
  task automatic run_walk(input logic [19:0] vpn, input bit scramble, input int hold_cycles,
      output int kind, output logic [19:0] o_vpn, output logic [19:0] o_pfn,
      output logic [1:0] o_code, output int lat, output bit hold_bad);
    int c0;
    kind = 0; o_vpn = '0; o_pfn = '0; o_code = '0; lat = 0; hold_bad = 1'b0;
    @(negedge clk);
    miss_vpn = vpn; tlb_miss = 1'b1; c0 = cyc;
    for (int i = 0; i < 400 && kind == 0; i++) begin
      @(negedge clk);
      if (scramble) begin miss_vpn = 20'($urandom); ptbr = $urandom; end
      if (refill_en) begin kind = 1; o_vpn = refill_vpn; o_pfn = refill_pfn; lat = cyc - c0; end
      else if (fault) begin kind = 2; o_vpn = fault_vpn; o_code = fault_code; lat = cyc - c0; end
    end
    if (kind == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL walk_timeout vpn=%h: no refill or fault within 400 cycles", vpn);
    end
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      if (mem_read_req || !busy) hold_bad = 1'b1;
    end
    tlb_miss = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    if (busy) begin
      tests_run++; tests_failed++;
      $display("FAIL return_idle vpn=%h: busy still %b", vpn, busy);
    end
  endtask

  task automatic setup_tables();
    mem.delete();
    ptbr = 32'h0001_0000;
    mem[32'h0001_0000] = 32'h0002_0001;
    mem[32'h0002_0004] = 32'h000A_1003;
    mem[32'h0002_0008] = 32'h000B_2003;
    mem_lat = 4; mem_mute = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; tlb_miss = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({refill_en, refill_vpn, refill_pfn, fault, fault_vpn, fault_code} !== '0) begin
      tests_failed++;
      $display("FAIL reset_strobes got %h want 0", {refill_en, refill_vpn, refill_pfn, fault, fault_vpn, fault_code});
    end
    tests_run++;
    if ({mem_read_req, mem_addr, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mem got req=%b addr=%h busy=%b want 0", mem_read_req, mem_addr, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset busy=%b want 0", busy); end
  endtask

  task automatic test_two_level();
    int kind, lat, base; logic [19:0] v, p; logic [1:0] c; bit hb;
    setup_tables();
    base = addr_log.size();
    run_walk(20'h00001, 1'b0, 0, kind, v, p, c, lat, hb);
    tests_run++; if (kind !== 1) begin tests_failed++; $display("FAIL two_level_kind got %0d want 1", kind); end
    tests_run++; if (v !== 20'h00001) begin tests_failed++; $display("FAIL two_level_vpn got %h want 00001", v); end
    tests_run++; if (p !== 20'h000A1) begin tests_failed++; $display("FAIL two_level_pfn got %h want 000a1", p); end
    tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL two_level_latency got %0d want 11", lat); end
    tests_run++;
    if (addr_log.size() - base != 2) begin
      tests_failed++; $display("FAIL two_level_accesses got %0d want 2", addr_log.size() - base);
    end else begin
      if (addr_log[base] !== 32'h0001_0000) begin tests_failed++; $display("FAIL two_level_l1_addr got %h want 00010000", addr_log[base]); end
      tests_run++;
      if (addr_log[base+1] !== 32'h0002_0004) begin tests_failed++; $display("FAIL two_level_l2_addr got %h want 00020004", addr_log[base+1]); end
    end
  endtask

  task automatic test_superpage();
    int kind, lat, base; logic [19:0] v, p; logic [1:0] c; bit hb;
    setup_tables();
    mem[32'h0001_000C] = 32'h0840_0003;
    base = addr_log.size();
    run_walk(20'h00C05, 1'b0, 0, kind, v, p, c, lat, hb);
    tests_run++; if (kind !== 1 || p !== 20'h08405) begin tests_failed++; $display("FAIL superpage_refill got kind=%0d pfn=%h want 1/08405", kind, p); end
    tests_run++; if (lat !== 6) begin tests_failed++; $display("FAIL superpage_latency got %0d want 6", lat); end
    tests_run++; if (addr_log.size() - base != 1) begin tests_failed++; $display("FAIL superpage_accesses got %0d want 1", addr_log.size() - base); end
    mem[32'h0001_000C] = 32'h0840_1003;
    run_walk(20'h00C05, 1'b0, 0, kind, v, p, c, lat, hb);
    tests_run++; if (kind !== 2 || c !== 2'd1) begin tests_failed++; $display("FAIL superpage_misaligned got kind=%0d code=%0d want 2/1", kind, c); end
  endtask

  task automatic test_invalid_nonleaf();
    int kind, lat; logic [19:0] v, p; logic [1:0] c; bit hb;
    setup_tables();
    mem[32'h0001_0000] = 32'h0002_0000;
    run_walk(20'h00001, 1'b0, 8, kind, v, p, c, lat, hb);
    tests_run++; if (kind !== 2 || c !== 2'd0) begin tests_failed++; $display("FAIL invalid_l1 got kind=%0d code=%0d want 2/0", kind, c); end
    tests_run++; if (v !== 20'h00001) begin tests_failed++; $display("FAIL invalid_fault_vpn got %h want 00001", v); end
    tests_run++; if (hb !== 1'b0) begin tests_failed++; $display("FAIL hold_stale_miss got req/idle during hold=%b want 0", hb); end
    mem[32'h0001_0000] = 32'h0002_0001;
    mem[32'h0002_0004] = 32'h000A_1001;
    run_walk(20'h00001, 1'b0, 8, kind, v, p, c, lat, hb);
    tests_run++; if (kind !== 2 || c !== 2'd2) begin tests_failed++; $display("FAIL nonleaf_l2 got kind=%0d code=%0d want 2/2", kind, c); end
    tests_run++; if (hb !== 1'b0) begin tests_failed++; $display("FAIL hold_after_nonleaf got %b want 0", hb); end
  endtask

  task automatic test_timeout();
    int kind, lat, bb; logic [19:0] v, p; logic [1:0] c; bit hb;
    setup_tables();
    mem_mute = 1'b1;
    bb = burst_log.size();
    run_walk(20'h00001, 1'b0, 0, kind, v, p, c, lat, hb);
    tests_run++; if (kind !== 2 || c !== 2'd3) begin tests_failed++; $display("FAIL timeout_fault got kind=%0d code=%0d want 2/3", kind, c); end
    tests_run++;
    if (burst_log.size() <= bb || burst_log[bb] !== 64) begin
      tests_failed++; $display("FAIL timeout_req_cycles got %0d want 64", (burst_log.size() > bb) ? burst_log[bb] : -1);
    end
    mem_mute = 1'b0; mem_lat = 64;
    run_walk(20'h00001, 1'b0, 0, kind, v, p, c, lat, hb);
    tests_run++; if (kind !== 1 || p !== 20'h000A1) begin tests_failed++; $display("FAIL ready_at_timeout got kind=%0d pfn=%h want 1/000a1", kind, p); end
    tests_run++; if (lat !== 131) begin tests_failed++; $display("FAIL ready_at_timeout_latency got %0d want 131", lat); end
    mem_lat = 4;
  endtask

  task automatic test_reset_mid_walk();
    int kind, lat, base, rc, fc; logic [19:0] v, p; logic [1:0] c; bit hb;
    setup_tables();
    base = addr_log.size();
    @(negedge clk);
    miss_vpn = 20'h00001; tlb_miss = 1'b1;
    for (int i = 0; i < 50 && addr_log.size() - base < 2; i++) @(negedge clk);
    tests_run++;
    if (addr_log.size() - base < 2) begin tests_failed++; $display("FAIL reset_mid_walk_reach_l2 got %0d accesses want 2", addr_log.size() - base); end
    @(negedge clk);
    rc = refill_cnt; fc = fault_cnt;
    rst = 1'b1; tlb_miss = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mem_read_req, mem_addr, busy, refill_en, refill_vpn, refill_pfn, fault, fault_vpn, fault_code} !== '0) begin
      tests_failed++; $display("FAIL reset_mid_walk_outputs got req=%b addr=%h busy=%b want 0", mem_read_req, mem_addr, busy);
    end
    rst = 1'b0;
    inject_req++;
    repeat (6) @(negedge clk);
    tests_run++;
    if (refill_cnt != rc || fault_cnt != fc || busy || mem_read_req) begin
      tests_failed++; $display("FAIL stale_ready_ignored got refills=%0d faults=%0d busy=%b want %0d/%0d/0", refill_cnt, fault_cnt, busy, rc, fc);
    end
    run_walk(20'h00001, 1'b0, 0, kind, v, p, c, lat, hb);
    tests_run++; if (kind !== 1 || p !== 20'h000A1) begin tests_failed++; $display("FAIL walk_after_reset got kind=%0d pfn=%h want 1/000a1", kind, p); end
  endtask

  task automatic test_back_to_back();
    int base, rc; bit got;
    setup_tables();
    @(negedge clk);
    miss_vpn = 20'h00001; tlb_miss = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = refill_en; end
    tests_run++; if (!got || refill_vpn !== 20'h00001) begin tests_failed++; $display("FAIL b2b_first got refill=%b vpn=%h want 1/00001", got, refill_vpn); end
    tlb_miss = 1'b0;
    @(negedge clk);
    base = addr_log.size(); rc = refill_cnt;
    miss_vpn = 20'h00002; tlb_miss = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = refill_en; end
    tests_run++;
    if (!got || refill_vpn !== 20'h00002 || refill_pfn !== 20'h000B2) begin
      tests_failed++; $display("FAIL b2b_second got refill=%b vpn=%h pfn=%h want 1/00002/000b2", got, refill_vpn, refill_pfn);
    end
    tests_run++;
    if (addr_log.size() - base != 2 || addr_log[base+1] !== 32'h0002_0008) begin
      tests_failed++; $display("FAIL b2b_l2_addr got n=%0d last=%h want 2/00020008", addr_log.size() - base, addr_log[addr_log.size()-1]);
    end
    tlb_miss = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++; if (refill_cnt - rc != 1) begin tests_failed++; $display("FAIL b2b_no_duplicate got %0d refills want 1", refill_cnt - rc); end
  endtask

  task automatic test_random();
    int kind, lat, base, ek, en, el, m; logic [19:0] v, p, ep, vpn; logic [1:0] c, ec;
    logic [31:0] a1, a2, pb, l1, l2; bit hb;
    for (int it = 0; it < 25; it++) begin
      mem.delete();
      pb = $urandom & 32'hFFFF_F000;
      vpn = 20'($urandom);
      m = $urandom_range(1, 6);
      mem_lat = m; mem_mute = 1'b0;
      a1 = {pb[31:12], vpn[19:10], 2'b00};
      l1 = $urandom;
      case ($urandom_range(0, 3))
        0: l1[0] = 1'b0;
        1: begin l1[1:0] = 2'b11; l1[21:12] = '0; end
        2: begin l1[1:0] = 2'b11; l1[12] = 1'b1; end
        default: l1[1:0] = 2'b01;
      endcase
      mem[a1] = l1;
      l2 = $urandom;
      l2[1:0] = 2'($urandom_range(0, 3));
      mem[{l1[31:12], vpn[9:0], 2'b00}] = l2;
      model_walk(pb, vpn, m, ek, ep, ec, en, a1, a2, el);
      ptbr = pb;
      base = addr_log.size();
      run_walk(vpn, 1'b1, $urandom_range(0, 3), kind, v, p, c, lat, hb);
      tests_run++;
      if (kind !== ek || v !== vpn) begin tests_failed++; $display("FAIL rnd%0d_kind got %0d vpn=%h want %0d vpn=%h", it, kind, v, ek, vpn); end
      tests_run++;
      if (ek == 1 && (p !== ep || lat !== el)) begin
        tests_failed++; $display("FAIL rnd%0d_refill got pfn=%h lat=%0d want %h/%0d", it, p, lat, ep, el);
      end else if (ek == 2 && c !== ec) begin
        tests_failed++; $display("FAIL rnd%0d_code got %0d want %0d", it, c, ec);
      end
      tests_run++;
      if (addr_log.size() - base != en || addr_log[base] !== a1 || (en == 2 && addr_log[base+1] !== a2)) begin
        tests_failed++; $display("FAIL rnd%0d_addrs got n=%0d first=%h want n=%0d %h %h", it, addr_log.size() - base, addr_log[base], en, a1, a2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_level();
    test_superpage();
    test_invalid_nonleaf();
    test_timeout();
    test_reset_mid_walk();
    test_back_to_back();
    test_random();
    tests_run++;
    if (both_seen !== 1'b0) begin tests_failed++; $display("FAIL refill_fault_overlap got %b want 0", both_seen); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
